circle_plotter: RTL
===================

Name: circle_plotter

Overview:
Parametrised midpoint-circle engine that draws one outline or filled circle per command into the 160x120 frame buffer path. It replaces the fixed per-colour circle state machines with one reusable engine. Centre, radius, colour and mode are latched on a start/busy/done handshake. Pixels are emitted on a plot/ready handshake, so an upstream arbiter can multiplex several engines onto the single VGA adapter port.

Parameters:
X_WIDTH, 8, width of x coordinate ports
Y_WIDTH, 7, width of y coordinate ports
R_WIDTH, 7, width of radius port
COLOUR_WIDTH, 3, colour code width
SCREEN_WIDTH, 160, visible columns; valid x is 0..SCREEN_WIDTH-1
SCREEN_HEIGHT, 120, visible rows; valid y is 0..SCREEN_HEIGHT-1

Ports:
CLOCK_50  in  1  system clock; all state on rising edge
resetn  in  1  asynchronous, active-low reset
start  in  1  command strobe; sampled only in IDLE
centre_x  in  X_WIDTH  circle centre column (unsigned)
centre_y  in  Y_WIDTH  circle centre row (unsigned)
radius  in  R_WIDTH  radius (unsigned)
colour_in  in  COLOUR_WIDTH  draw colour
fill  in  1  0 = outline, 1 = filled disc
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the command completes
x  out  X_WIDTH  pixel column
y  out  Y_WIDTH  pixel row
colour  out  COLOUR_WIDTH  pixel colour (latched colour_in)
plot  out  1  pixel valid
ready  in  1  downstream accepts pixel when plot && ready

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, done=0, plot=0, x=0, y=0, colour=0.
- Reset mid-command aborts immediately. No further pixels or done are produced.
- IDLE: start=1 latches all command inputs. The next state is INIT and busy=1 on the next edge. start is ignored while busy.
- INIT: ox=r, oy=0, crit=1-r. crit is signed, R_WIDTH+3 bits. All coordinate arithmetic is signed, X_WIDTH+2 bits. Nothing wraps.
- Special case r=0: emit the single centre pixel, then finish.
- Loop while oy<=ox:
  - Outline mode, EMIT: walk 8 candidates in this fixed order: (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-ox,cy+oy), (cx-oy,cy+ox), (cx+ox,cy-oy), (cx+oy,cy-ox), (cx-ox,cy-oy), (cx-oy,cy-ox).
  - Duplicate candidates are emitted as-is.
  - Fill mode, SPAN: draw 4 horizontal spans in order:
    - row cy+oy, x from cx-ox to cx+ox
    - row cy-oy, same x range
    - row cy+ox, x from cx-oy to cx+oy
    - row cy-ox, same x range
  - Each span is walked left to right, one pixel per accepted handshake.
  - STEP, one cycle: oy++. If crit<=0, crit+=2*oy+1. Otherwise ox--, then crit+=2*(oy-ox)+1, using the new oy and ox.
- Clipping:
  - Outline: any candidate with x<0, x>=SCREEN_WIDTH, y<0 or y>=SCREEN_HEIGHT is skipped. It costs one cycle with plot=0.
  - Fill: a span on an off-screen row is skipped in one cycle. Span x limits are clamped to 0..SCREEN_WIDTH-1. A span that is empty after clamping is skipped.
- Pixel handshake:
  - While plot=1 and ready=0, x, y and colour hold stable and the engine does not advance.
  - A transfer occurs on an edge where plot && ready. The next pixel may be presented on the following cycle, one pixel per cycle at full throughput.
  - plot must not depend combinationally on ready.
- Completion: when the loop exits (oy>ox), go to DONE.
  - DONE: done=1 for exactly one cycle, busy drops to 0 in the same cycle, then return to IDLE.
  - done never asserts while a pixel is outstanding.
- Latency: start accepted at edge N. The first plot can be high no earlier than edge N+2.
- Off-screen centres are legal; every pixel is simply clipped.

Test Plan:
1. Outline, centre (40,40), r=1, ready=1 -> exactly 16 pixels in order: (41,40),(40,41),(39,40),(40,41),(41,40),(40,39),(39,40),(40,39), then (41,41)x2,(39,41)x2,(41,39)x2,(39,39)x2. Then one done pulse; busy=0.
2. Fill, centre (40,40), r=1 -> 20 pixels: row40 x39..41 twice, (40,41), (40,39), then rows 41/39/41/39 each x39..41. All colour=colour_in.
3. Outline, centre (0,0), r=1 -> 6 pixels: (1,0),(0,1),(0,1),(1,0),(1,1),(1,1). No negative or wrapped coordinates; done asserts.
4. r=0, centre (159,119) -> one pixel (159,119), then done. Also check: start pulsed while busy is ignored, with identical output stream and a single done.
5. Backpressure: test 1 with ready=0 for 5 cycles after the 3rd pixel -> x/y/colour stable at (39,40) and plot held high for all 5 cycles. Stream identical to test 1.
6. Reset: resetn low during test 2 after 7 pixels -> outputs immediately go to 0 and no done. A fresh start after release reproduces the full test 2 stream.

Source files
------------

// File: rtl/circle_plotter_if.sv
// Command (start/busy/done) and pixel (plot/ready) bundle for one circle engine.
// The engine takes the slave side; the requester or arbiter takes the master side.
interface circle_plotter_if #(
  parameter int X_WIDTH      = 8,
  parameter int Y_WIDTH      = 7,
  parameter int R_WIDTH      = 7,
  parameter int COLOUR_WIDTH = 3
);
  logic                    start;
  logic [X_WIDTH-1:0]      centre_x;
  logic [Y_WIDTH-1:0]      centre_y;
  logic [R_WIDTH-1:0]      radius;
  logic [COLOUR_WIDTH-1:0] colour_in;
  logic                    fill;
  logic                    busy;
  logic                    done;
  logic [X_WIDTH-1:0]      x;
  logic [Y_WIDTH-1:0]      y;
  logic [COLOUR_WIDTH-1:0] colour;
  logic                    plot;
  logic                    ready;

  modport master (
    output start, centre_x, centre_y, radius, colour_in, fill, ready,
    input  busy, done, x, y, colour, plot
  );

  modport slave (
    input  start, centre_x, centre_y, radius, colour_in, fill, ready,
    output busy, done, x, y, colour, plot
  );
endinterface

// File: rtl/circle_plotter.sv
// Midpoint-circle engine (outline or filled) with clipping; first pixel 2 cycles after start.
// Pixels are registered and held while plot && !ready; one pixel per cycle at full throughput.
module circle_plotter #(
  parameter int X_WIDTH       = 8,
  parameter int Y_WIDTH       = 7,
  parameter int R_WIDTH       = 7,
  parameter int COLOUR_WIDTH  = 3,
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  circle_plotter_if.slave  bus
);
  localparam int CW = X_WIDTH + 2;
  localparam int KW = R_WIDTH + 3;
  localparam logic signed [CW-1:0] ONE    = CW'(1);
  localparam logic signed [CW-1:0] ZERO   = '0;
  localparam logic signed [CW-1:0] SW_S   = CW'(SCREEN_WIDTH);
  localparam logic signed [CW-1:0] SH_S   = CW'(SCREEN_HEIGHT);
  localparam logic signed [KW-1:0] K_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_EMIT, S_SPAN_SETUP, S_SPAN, S_STEP, S_DONE
  } state_t;

  state_t                  state;
  logic [X_WIDTH-1:0]      cx;
  logic [Y_WIDTH-1:0]      cy;
  logic [R_WIDTH-1:0]      rad;
  logic                    fill_r;
  logic signed [CW-1:0]    ox, oy;
  logic signed [KW-1:0]    crit;
  logic [3:0]              idx;
  logic [2:0]              sidx;
  logic [X_WIDTH-1:0]      span_end;
  logic                    busy_r, done_r, plot_r;
  logic [X_WIDTH-1:0]      x_r;
  logic [Y_WIDTH-1:0]      y_r;
  logic [COLOUR_WIDTH-1:0] colour_r;

  logic signed [CW-1:0] cx_s, cy_s, r_s;
  logic signed [CW-1:0] cand_x, cand_y;
  logic                 cand_ok;
  logic signed [CW-1:0] row, half, lo, hi, lo_c, hi_c;
  logic                 span_ok;
  logic signed [CW-1:0] oy_n, ox_n, inc;
  logic signed [KW-1:0] crit_n;
  logic                 stall;

  assign cx_s  = $signed({{(CW-X_WIDTH){1'b0}}, cx});
  assign cy_s  = $signed({{(CW-Y_WIDTH){1'b0}}, cy});
  assign r_s   = $signed({{(CW-R_WIDTH){1'b0}}, bus.radius});
  assign stall = plot_r && !bus.ready;

  always_comb begin
    cand_x = cx_s;
    cand_y = cy_s;
    case (idx[2:0])
      3'd0: begin cand_x = cx_s + ox; cand_y = cy_s + oy; end
      3'd1: begin cand_x = cx_s + oy; cand_y = cy_s + ox; end
      3'd2: begin cand_x = cx_s - ox; cand_y = cy_s + oy; end
      3'd3: begin cand_x = cx_s - oy; cand_y = cy_s + ox; end
      3'd4: begin cand_x = cx_s + ox; cand_y = cy_s - oy; end
      3'd5: begin cand_x = cx_s + oy; cand_y = cy_s - ox; end
      3'd6: begin cand_x = cx_s - ox; cand_y = cy_s - oy; end
      default: begin cand_x = cx_s - oy; cand_y = cy_s - ox; end
    endcase
    cand_ok = (cand_x >= ZERO) && (cand_x < SW_S) && (cand_y >= ZERO) && (cand_y < SH_S);
  end

  // Spans 0/1 use half-width ox on rows cy+-oy; spans 2/3 use oy on rows cy+-ox.
  always_comb begin
    row  = cy_s;
    half = ox;
    case (sidx[1:0])
      2'd0:    begin row = cy_s + oy; half = ox; end
      2'd1:    begin row = cy_s - oy; half = ox; end
      2'd2:    begin row = cy_s + ox; half = oy; end
      default: begin row = cy_s - ox; half = oy; end
    endcase
    lo      = cx_s - half;
    hi      = cx_s + half;
    lo_c    = (lo < ZERO) ? ZERO : lo;
    hi_c    = (hi > SW_S - ONE) ? SW_S - ONE : hi;
    span_ok = (row >= ZERO) && (row < SH_S) && (lo_c <= hi_c);
  end

  always_comb begin
    oy_n   = oy + ONE;
    ox_n   = (crit <= K_ZERO) ? ox : ox - ONE;
    inc    = (crit <= K_ZERO) ? ((oy_n <<< 1) + ONE) : (((oy_n - ox_n) <<< 1) + ONE);
    crit_n = crit + KW'(inc);
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state    <= S_IDLE;
      cx       <= '0;
      cy       <= '0;
      rad      <= '0;
      fill_r   <= 1'b0;
      ox       <= '0;
      oy       <= '0;
      crit     <= '0;
      idx      <= '0;
      sidx     <= '0;
      span_end <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      plot_r   <= 1'b0;
      x_r      <= '0;
      y_r      <= '0;
      colour_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            cx       <= bus.centre_x;
            cy       <= bus.centre_y;
            rad      <= bus.radius;
            fill_r   <= bus.fill;
            colour_r <= bus.colour_in;
            busy_r   <= 1'b1;
            state    <= S_INIT;
          end
        end
        S_INIT: begin
          ox   <= $signed({{(CW-R_WIDTH){1'b0}}, rad});
          oy   <= ZERO;
          crit <= KW'(ONE - $signed({{(CW-R_WIDTH){1'b0}}, rad}));
          sidx <= '0;
          // A zero radius reuses the last outline candidate, which is the centre itself.
          if (rad == '0) begin
            idx   <= 4'd7;
            state <= S_EMIT;
          end else begin
            idx   <= 4'd0;
            state <= fill_r ? S_SPAN_SETUP : S_EMIT;
          end
        end
        S_EMIT: begin
          if (!stall) begin
            if (idx == 4'd8) begin
              plot_r <= 1'b0;
              state  <= S_STEP;
            end else begin
              plot_r <= cand_ok;
              if (cand_ok) begin
                x_r <= cand_x[X_WIDTH-1:0];
                y_r <= cand_y[Y_WIDTH-1:0];
              end
              idx <= idx + 4'd1;
            end
          end
        end
        S_SPAN_SETUP: begin
          if (sidx == 3'd4) begin
            state <= S_STEP;
          end else if (span_ok) begin
            x_r      <= lo_c[X_WIDTH-1:0];
            y_r      <= row[Y_WIDTH-1:0];
            span_end <= hi_c[X_WIDTH-1:0];
            plot_r   <= 1'b1;
            state    <= S_SPAN;
          end else begin
            sidx <= sidx + 3'd1;
          end
        end
        S_SPAN: begin
          if (plot_r && bus.ready) begin
            if (x_r == span_end) begin
              plot_r <= 1'b0;
              sidx   <= sidx + 3'd1;
              state  <= S_SPAN_SETUP;
            end else begin
              x_r <= x_r + 1'b1;
            end
          end
        end
        S_STEP: begin
          oy   <= oy_n;
          ox   <= ox_n;
          crit <= crit_n;
          idx  <= '0;
          sidx <= '0;
          if (oy_n <= ox_n) begin
            state <= fill_r ? S_SPAN_SETUP : S_EMIT;
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          done_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.plot   = plot_r;
  assign bus.x      = x_r;
  assign bus.y      = y_r;
  assign bus.colour = colour_r;
endmodule
